hash_set_matcher: RTL and testbench

Parameterised hash store-and-lookup engine for the cracking pipeline: target hashes are loaded once, then each candidate hash produced by the hashing core is checked against the stored set. It generalises the fixed 128×128-bit store with:
- configurable width and depth;
- a time-multiplexed comparator of configurable lane count;
- duplicate rejection on load, a full indication, a clear command, and reporting of the matching entry's index.

It sits between the hash core's output and the result/reporting logic.

---
 rtl/hash_set_matcher.sv | 143 ++++++++++++++
 tb/tb_hash_set_matcher.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hash_set_matcher.sv
// Hash store-and-lookup engine: loads target hashes once, then checks candidates
// against the stored set with a LANES-wide time-multiplexed comparator.
module hash_set_matcher #(
    parameter int HASH_WIDTH = 128,
    parameter int DEPTH      = 128,
    parameter int LANES      = 8,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // the source holds cmd_* stable until then. resp_valid is a one-cycle pulse
    // with no back-pressure, exactly one per accepted command.
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    input  logic [HASH_WIDTH-1:0] cmd_hash,
    output logic                  cmd_ready,
    output logic                  resp_valid,
    output logic                  resp_match,
    output logic [IDX_W-1:0]      resp_index,
    output logic                  resp_stored,
    output logic                  resp_full,
    output logic [IDX_W:0]        count,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    localparam logic [IDX_W:0] LANES_W = (IDX_W+1)'(LANES);
    localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);

    logic [HASH_WIDTH-1:0] mem [DEPTH];
    logic [1:0]            state;
    logic [1:0]            op_q;
    logic [HASH_WIDTH-1:0] hash_q;
    logic [IDX_W:0]        base;
    logic [IDX_W:0]        next_base;
    logic [IDX_W:0]        lane_idx;
    logic                  any_hit;
    logic [IDX_W-1:0]      hit_idx;

    assign cmd_ready  = (state == S_IDLE) && !rst;
    assign resp_valid = (state == S_RESP);
    assign state_dbg  = state;
    assign next_base  = base + LANES_W;

    // Walk lanes from the top down so the lowest hitting index wins.
    always_comb begin
        any_hit  = 1'b0;
        hit_idx  = '0;
        lane_idx = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            lane_idx = base + (IDX_W+1)'(l);
            if ((lane_idx < count) && (mem[lane_idx[IDX_W-1:0]] == hash_q)) begin
                any_hit = 1'b1;
                hit_idx = lane_idx[IDX_W-1:0];
            end
        end
    end

    // Storage is not reset; only entries below count are ever compared.
    always_ff @(posedge clk) begin
        if (state == S_WRITE)
            mem[count[IDX_W-1:0]] <= hash_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            base        <= '0;
            op_q        <= '0;
            hash_q      <= '0;
            resp_match  <= 1'b0;
            resp_index  <= '0;
            resp_stored <= 1'b0;
            resp_full   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_q   <= cmd_op;
                        hash_q <= cmd_hash;
                        base   <= '0;
                        if (cmd_op == OP_CLEAR) begin
                            count       <= '0;
                            resp_match  <= 1'b0;
                            resp_index  <= '0;
                            resp_stored <= 1'b0;
                            resp_full   <= 1'b0;
                            state       <= S_RESP;
                        end else begin
                            state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (any_hit) begin
                        resp_match  <= 1'b1;
                        resp_index  <= hit_idx;
                        resp_stored <= 1'b0;
                        resp_full   <= 1'b0;
                        state       <= S_RESP;
                    end else if (next_base < count) begin
                        base <= next_base;
                    end else if (op_q != OP_ADD) begin
                        resp_match  <= 1'b0;
                        resp_index  <= '0;
                        resp_stored <= 1'b0;
                        resp_full   <= 1'b0;
                        state       <= S_RESP;
                    end else if (count < DEPTH_W) begin
                        state <= S_WRITE;
                    end else begin
                        resp_match  <= 1'b0;
                        resp_index  <= '0;
                        resp_stored <= 1'b0;
                        resp_full   <= 1'b1;
                        state       <= S_RESP;
                    end
                end
                S_WRITE: begin
                    resp_match  <= 1'b0;
                    resp_index  <= count[IDX_W-1:0];
                    resp_stored <= 1'b1;
                    resp_full   <= 1'b0;
                    count       <= count + 1'b1;
                    state       <= S_RESP;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_set_matcher.sv
// Directed, table-driven bench for hash_set_matcher at DEPTH=8, LANES=2.
module tb_hash_set_matcher;

    localparam int HW    = 128;
    localparam int DEPTH = 8;
    localparam int LANES = 2;
    localparam int IDX_W = 3;

    localparam logic [1:0] ADD   = 2'b00;
    localparam logic [1:0] CHECK = 2'b01;
    localparam logic [1:0] CLEAR = 2'b10;
    localparam logic [1:0] OP11  = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic [HW-1:0]    cmd_hash = '0;
    logic             cmd_ready;
    logic             resp_valid;
    logic             resp_match;
    logic [IDX_W-1:0] resp_index;
    logic             resp_stored;
    logic             resp_full;
    logic [IDX_W:0]   count;
    logic [1:0]       state_dbg;

    int total = 0;
    int bad   = 0;

    hash_set_matcher #(.HASH_WIDTH(HW), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_hash(cmd_hash),
        .cmd_ready(cmd_ready), .resp_valid(resp_valid), .resp_match(resp_match),
        .resp_index(resp_index), .resp_stored(resp_stored), .resp_full(resp_full),
        .count(count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [HW-1:0] hash;
        logic          m;
        int            idx;
        logic          st;
        logic          fu;
        int            cnt;
        int            lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic void add_vec(input logic [1:0] op, input logic [HW-1:0] h,
                                    input logic m, input int idx, input logic st,
                                    input logic fu, input int cnt, input int lat);
        vec_t v;
        v.op = op; v.hash = h; v.m = m; v.idx = idx; v.st = st; v.fu = fu;
        v.cnt = cnt; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Issue one command; lat counts negedges after the accept edge up to resp_valid.
    task automatic do_cmd(input logic [1:0] op, input logic [HW-1:0] h, output int lat);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_hash  = h;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        if (!resp_valid) begin
            chk("resp_timeout", 0, 1);
            lat = -1;
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int lat;
        string tag;
        do_cmd(v.op, v.hash, lat);
        tag = $sformatf("v%0d", n);
        chk({tag, "_lat"},    lat,               v.lat);
        chk({tag, "_match"},  int'(resp_match),  int'(v.m));
        chk({tag, "_index"},  int'(resp_index),  v.idx);
        chk({tag, "_stored"}, int'(resp_stored), int'(v.st));
        chk({tag, "_full"},   int'(resp_full),   int'(v.fu));
        chk({tag, "_count"},  int'(count),       v.cnt);
        @(negedge clk);
        chk({tag, "_pulse"},  int'(resp_valid),  0);
    endtask

    initial begin
        int lat;
        int seen;

        // ---- reset state ----
        #1;
        chk("rst_ready",  int'(cmd_ready),  0);
        chk("rst_valid",  int'(resp_valid), 0);
        chk("rst_count",  int'(count),      0);
        repeat (2) @(negedge clk);
        chk("rst_fields", int'({resp_match, resp_index, resp_stored, resp_full}), 0);
        rst = 1'b0;
        #1 chk("rel_ready", int'(cmd_ready), 1);

        // ---- directed table: op, hash, match, index, stored, full, count, latency ----
        add_vec(ADD,   {{15{8'hAA}}, 8'h01}, 0, 0, 1, 0, 1, 3);
        add_vec(ADD,   128'h11, 0, 1, 1, 0, 2, 3);
        add_vec(ADD,   128'h22, 0, 2, 1, 0, 3, 3);
        add_vec(ADD,   128'h33, 0, 3, 1, 0, 4, 4);
        add_vec(CHECK, 128'h33, 1, 3, 0, 0, 4, 3);
        add_vec(CHECK, 128'h44, 0, 0, 0, 0, 4, 3);
        add_vec(ADD,   128'h22, 1, 2, 0, 0, 4, 3);
        add_vec(OP11,  128'h11, 1, 1, 0, 0, 4, 2);
        add_vec(ADD,   128'h55, 0, 4, 1, 0, 5, 4);
        add_vec(ADD,   128'h66, 0, 5, 1, 0, 6, 5);
        add_vec(ADD,   128'h77, 0, 6, 1, 0, 7, 5);
        add_vec(ADD,   128'h88, 0, 7, 1, 0, 8, 6);
        add_vec(ADD,   128'h99, 0, 0, 0, 1, 8, 5);
        add_vec(ADD,   128'h88, 1, 7, 0, 0, 8, 5);
        add_vec(CHECK, {{15{8'hAA}}, 8'h01}, 1, 0, 0, 0, 8, 2);
        add_vec(CLEAR, 128'h55, 0, 0, 0, 0, 0, 1);
        add_vec(CHECK, 128'h33, 0, 0, 0, 0, 0, 2);
        add_vec(ADD,   128'h33, 0, 0, 1, 0, 1, 3);
        add_vec(CHECK, 128'h22, 0, 0, 0, 0, 1, 2);
        add_vec(ADD,   128'h11, 0, 1, 1, 0, 2, 3);
        add_vec(ADD,   128'h22, 0, 2, 1, 0, 3, 3);
        add_vec(ADD,   128'h44, 0, 3, 1, 0, 4, 4);
        add_vec(ADD,   128'h55, 0, 4, 1, 0, 5, 4);

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // ---- reset during SCAN of an ADD with count=5 ----
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = ADD;
        cmd_hash  = 128'h66;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_scan_state", int'(state_dbg), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", int'(cmd_ready),  0);
        chk("mid_rst_count", int'(count),      0);
        chk("mid_rst_valid", int'(resp_valid), 0);
        @(negedge clk);
        chk("mid_rst_ready2", int'(cmd_ready), 0);
        rst = 1'b0;
        #1 chk("mid_rel_ready", int'(cmd_ready), 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("mid_no_resp", seen, 0);
        chk("mid_count_after", int'(count), 0);

        // Store restarts empty after the aborted ADD.
        do_cmd(CHECK, 128'h66, lat);
        chk("post_chk_lat",   lat, 2);
        chk("post_chk_match", int'(resp_match), 0);
        @(negedge clk);
        do_cmd(ADD, 128'h66, lat);
        chk("post_add_lat",    lat, 3);
        chk("post_add_stored", int'(resp_stored), 1);
        chk("post_add_index",  int'(resp_index), 0);
        chk("post_add_count",  int'(count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
